uart_tx: RTL and testbench

//  UART serial transmitter; counterpart of the team's Rx datapath/controller pair.

---
 rtl/uart_pkg.sv | 15 +
 rtl/control_tx.sv | 73 +++++++
 rtl/counter_n_bit.sv | 21 ++
 rtl/uart_tx.sv | 107 ++++++++++
 tb/tb_uart_tx.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmitter
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int TICK_W     = $clog2(OVERSAMPLE);

endpackage

// File: rtl/control_tx.sv
// rtl/control_tx.sv - transmitter FSM with next-state and enable generation
import uart_pkg::*;

module Control_Tx (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      tx_valid,
    input  logic      bit_end,
    input  logic      last_bit,
    input  logic      parity_en,
    output tx_state_t state,
    output tx_state_t state_next,
    output logic      accept,
    output logic      shift,
    output logic      tick_clr,
    output logic      bit_clr,
    output logic      tx_done
);

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next state and per-cycle strobes; tx_done is masked in reset so an aborted frame never reports completion
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        shift      = 1'b0;
        bit_clr    = 1'b0;
        tx_done    = 1'b0;
        case (state)
            IDLE: begin
                if (tx_valid) begin
                    accept     = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_clr    = 1'b1;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift = 1'b1;
                    if (last_bit) begin
                        state_next = parity_en ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    tx_done    = rst_n;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        tick_clr = (state_next != state) || (state == IDLE);
    end

endmodule

// File: rtl/counter_n_bit.sv
// rtl/counter_n_bit.sv - clearable, enabled up-counter
module Counter_n_bit #(
    parameter int width = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [width-1:0] count
);

    // clear has priority over counting so a state entry always starts from zero
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART serial transmitter with 16x oversampled bit timing
import uart_pkg::*;

module uart_tx #(
    parameter int msg_size = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                baud_tick,
    input  logic                tx_valid,
    input  logic [msg_size-1:0] tx_data,
    input  logic                parity_check,
    input  logic                parity_type_even_odd,
    output logic                tx_ready,
    output logic                Tx,
    output logic                tx_done
);

    localparam int BIT_W = $clog2(msg_size);

    tx_state_t           state;
    tx_state_t           state_next;
    logic                accept;
    logic                shift;
    logic                tick_clr;
    logic                bit_clr;
    logic                bit_end;
    logic                last_bit;
    logic [TICK_W-1:0]   tick_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [msg_size-1:0] shreg;
    logic [msg_size-1:0] shreg_next;
    logic                par_bit;
    logic                parity_en;
    logic                tx_next;

    assign bit_end  = baud_tick && (tick_cnt == TICK_W'(OVERSAMPLE - 1));
    assign last_bit = (bit_cnt == BIT_W'(msg_size - 1));
    assign tx_ready = (state == IDLE);

    Control_Tx u_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_valid   (tx_valid),
        .bit_end    (bit_end),
        .last_bit   (last_bit),
        .parity_en  (parity_en),
        .state      (state),
        .state_next (state_next),
        .accept     (accept),
        .shift      (shift),
        .tick_clr   (tick_clr),
        .bit_clr    (bit_clr),
        .tx_done    (tx_done)
    );

    Counter_n_bit #(.width(TICK_W)) u_tick_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tick_clr),
        .en    (baud_tick),
        .count (tick_cnt)
    );

    Counter_n_bit #(.width(BIT_W)) u_bit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bit_clr),
        .en    (shift),
        .count (bit_cnt)
    );

    // next shift-register contents and the line level for the state being entered
    always_comb begin
        shreg_next = shreg;
        if (accept) begin
            shreg_next = tx_data;
        end else if (shift) begin
            shreg_next = shreg >> 1;
        end
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shreg_next[0];
            PARITY:  tx_next = par_bit;
            default: tx_next = 1'b1;
        endcase
    end

    // datapath registers; frame options are frozen at accept
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg     <= '0;
            par_bit   <= 1'b0;
            parity_en <= 1'b0;
            Tx        <= 1'b1;
        end else begin
            shreg <= shreg_next;
            Tx    <= tx_next;
            if (accept) begin
                par_bit   <= ^tx_data ^ ~parity_type_even_odd;
                parity_en <= parity_check;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud_tick = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       parity_check = 1'b0;
    logic       parity_type_even_odd = 1'b0;
    logic       tx_ready;
    logic       Tx;
    logic       tx_done;

    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   ready_cnt = 0;
    int   tick_mode = 0;
    logic line_q[$];

    uart_tx #(.msg_size(8)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .baud_tick            (baud_tick),
        .tx_valid             (tx_valid),
        .tx_data              (tx_data),
        .parity_check         (parity_check),
        .parity_type_even_odd (parity_type_even_odd),
        .tx_ready             (tx_ready),
        .Tx                   (Tx),
        .tx_done              (tx_done)
    );

    always #5 clk = ~clk;

    // baud tick source: regular every other clock, or irregular random gaps
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            if (tick_mode == 0) begin
                ph = ph ^ 1;
                baud_tick = (ph == 1);
            end else begin
                baud_tick = ($urandom_range(0, 1) == 1);
            end
        end
    end

    // line monitor: record Tx for every tick the transmitter will count
    always @(negedge clk) begin
        if (rst_n) begin
            if (baud_tick && !tx_ready) line_q.push_back(Tx);
            if (tx_done) done_cnt++;
            if (tx_ready) ready_cnt++;
        end
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic pc, input logic pt, input logic hold);
        int n;
        tx_data = d;
        parity_check = pc;
        parity_type_even_odd = pt;
        tx_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!tx_ready && n < 5000);
        if (!tx_ready) check_val("accept_timeout", 0, 1);
        line_q.delete();
        done_cnt = 0;
        @(posedge clk);
        #1;
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input logic [15:0] exp_bits, input int nslots);
        int          n;
        int          bad;
        int          slot;
        logic [15:0] got;
        n = 0;
        while (done_cnt == 0 && n < 5000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_val({tag, "_done"}, done_cnt, 1);
        check_val({tag, "_ticks"}, line_q.size(), nslots * 16);
        got = '0;
        bad = 0;
        for (int i = 0; i < line_q.size(); i++) begin
            slot = i / 16;
            if (slot < 16) begin
                if (i % 16 == 0) got[slot] = line_q[i];
                else if (line_q[i] !== line_q[slot * 16]) bad++;
            end
        end
        check_val({tag, "_bits"}, int'(got), int'(exp_bits));
        check_val({tag, "_stable"}, bad, 0);
    endtask

    // reference frame: slot 0 start, data LSB first, optional parity, stop
    task automatic model_frame(input logic [7:0] d, input logic pc, input logic pt,
                               output logic [15:0] bits, output int nslots);
        int ones;
        ones = 0;
        bits = '0;
        for (int i = 0; i < 8; i++) begin
            bits[i + 1] = d[i];
            if (d[i]) ones++;
        end
        if (pc) begin
            bits[9] = pt ? (ones % 2 == 1) : (ones % 2 == 0);
            bits[10] = 1'b1;
            nslots = 11;
        end else begin
            bits[9] = 1'b1;
            nslots = 10;
        end
    endtask

    initial begin
        logic [15:0] mb;
        int          ms;
        int          n;
        logic [7:0]  rd;
        logic        rpc;
        logic        rpt;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_tx", Tx, 1);
        check_val("rst_ready", tx_ready, 1);
        check_val("rst_done", tx_done, 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_val("idle_tx", Tx, 1);
        check_val("idle_ready", tx_ready, 1);

        // A5, even parity / odd parity / no parity
        send(8'hA5, 1'b1, 1'b1, 1'b0);
        collect("a5_even", 16'h054A, 11);
        send(8'hA5, 1'b1, 1'b0, 1'b0);
        collect("a5_odd", 16'h074A, 11);
        send(8'hA5, 1'b0, 1'b1, 1'b0);
        collect("a5_nopar", 16'h034A, 10);

        // input changes and a tx_valid pulse mid-frame are ignored
        send(8'hA5, 1'b1, 1'b1, 1'b0);
        repeat (60) @(negedge clk);
        tx_data = 8'h3C;
        parity_check = 1'b0;
        parity_type_even_odd = 1'b0;
        tx_valid = 1'b1;
        @(negedge clk);
        check_val("busy_ready", tx_ready, 0);
        tx_valid = 1'b0;
        collect("a5_busy", 16'h054A, 11);
        repeat (60) @(negedge clk);
        check_val("after_busy_ready", tx_ready, 1);
        check_val("after_busy_tx", Tx, 1);
        check_val("after_busy_done", done_cnt, 1);

        // back-to-back frames with tx_valid held high
        send(8'h00, 1'b0, 1'b1, 1'b1);
        ready_cnt = 0;
        repeat (20) @(negedge clk);
        tx_data = 8'hFF;
        collect("b2b_00", 16'h0200, 10);
        line_q.delete();
        done_cnt = 0;
        collect("b2b_ff", 16'h03FE, 10);
        tx_valid = 1'b0;
        check_val("b2b_ready_gap", ready_cnt, 1);
        repeat (4) @(negedge clk);

        // reset in the middle of the data bits
        send(8'hA5, 1'b1, 1'b1, 1'b0);
        n = 0;
        while (line_q.size() < 16 + 40 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_val("midrst_tx", Tx, 1);
        check_val("midrst_ready", tx_ready, 1);
        check_val("midrst_done", tx_done, 0);
        rst_n = 1'b1;
        repeat (400) @(negedge clk);
        check_val("midrst_no_done", done_cnt, 0);
        check_val("midrst_idle_tx", Tx, 1);

        // random words and parity settings with irregular tick gaps
        tick_mode = 1;
        for (int f = 0; f < 100; f++) begin
            rd = 8'($urandom_range(0, 255));
            rpc = 1'($urandom_range(0, 1));
            rpt = 1'($urandom_range(0, 1));
            model_frame(rd, rpc, rpt, mb, ms);
            send(rd, rpc, rpt, 1'b0);
            collect("rand", mb, ms);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
